// File: rtl/spm_pkg.sv
// Shared types for the SpMV row tagger: FSM state encoding and output token layout.
// Row-count and nnz-count widths come from `DIM_W / `NNZ_W (defaults below).
`ifndef DIM_W
`define DIM_W 16
`endif
`ifndef NNZ_W
`define NNZ_W 32
`endif

package spm_pkg;

   localparam int SPM_DATA_W = 32;
   localparam int SPM_DIM_W  = `DIM_W;
   localparam int SPM_NNZ_W  = `NNZ_W;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM,
      DONE
   } tag_state_t;

   typedef struct packed {
      logic [SPM_DATA_W-1:0] val;
      logic [SPM_DATA_W-1:0] col_idx;
      logic [SPM_DIM_W-1:0]  row_idx;
      logic                  last;
      logic                  empty;
   } tag_tok_t;

endpackage

// File: rtl/spm_row_tagger_fifo.sv
// Two-entry beat FIFO with a lane read pointer; the head beat pops once the pointer
// passes its last valid lane (lane before the lowest set mask bit above lane 0).
module spm_beat_fifo
   import spm_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int LANE_W = 32
) (
   input  logic                           clk,
   input  logic                           clr,
   input  logic                           wr_val,
   input  logic [NUM_CH-1:0][LANE_W-1:0]  wr_data,
   input  logic [NUM_CH-1:0]              wr_mask,
   input  logic                           adv,
   output logic                           rdy,
   output logic                           empty,
   output logic [LANE_W-1:0]              head
);

   localparam int LB = $clog2(NUM_CH);

   logic [NUM_CH-1:0][LANE_W-1:0] mem [2];
   logic [NUM_CH-1:0]             mask_mem [2];
   logic                          wr_ptr;
   logic                          rd_ptr;
   logic [1:0]                    cnt;
   logic [LB-1:0]                 lane;
   logic [LB-1:0]                 last_lane;
   logic                          wr;
   logic                          pop;

   // ready is taken from registered occupancy, so a pop frees the slot one cycle later
   assign rdy   = (cnt != 2'd2);
   assign empty = (cnt == 2'd0);
   assign wr    = wr_val && rdy;
   assign head  = mem[rd_ptr][lane];
   assign pop   = adv && !empty && (lane == last_lane);

   always_comb begin
      last_lane = LB'(NUM_CH - 1);
      for (int i = NUM_CH - 1; i >= 1; i--) begin
         if (mask_mem[rd_ptr][i]) last_lane = LB'(i - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
         lane   <= '0;
      end else begin
         if (wr) wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         if (adv && !empty) lane <= pop ? '0 : lane + 1'b1;
         case ({wr, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr]      <= wr_data;
         mask_mem[wr_ptr] <= wr_mask;
      end
   end

endmodule

// File: rtl/spm_row_tagger.sv
// Serializes buffered nnz/row-length beats into row-tagged tokens, one per cycle.
// Optional checking (ovf_err, cnt_err) is built when SPM_ROW_TAGGER_CHECK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for spmv_init to fall
// LOAD   | fetch next row length; empty rows emit a marker token here
// STREAM | emit elements of the current row, rem counts down to 1
// DONE   | all rows emitted; remaining buffered data ignored
module spm_row_tagger
   import spm_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int DATA_W = SPM_DATA_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           spmv_init,
   input  logic [SPM_DIM_W-1:0]           spm_nr,
   input  logic [SPM_NNZ_W-1:0]           spm_nnz,
   input  logic                           nnz_beat_val,
   input  logic [NUM_CH-1:0][DATA_W-1:0]  spm_val,
   input  logic [NUM_CH-1:0][DATA_W-1:0]  spm_col_idx,
   input  logic [NUM_CH-1:0]              last_not_valid,
   output logic                           nnz_rdy,
   input  logic                           len_beat_val,
   input  logic [NUM_CH-1:0][DATA_W-1:0]  spm_row_len,
   output logic                           len_rdy,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic [DATA_W-1:0]              out_val,
   output logic [DATA_W-1:0]              out_col_idx,
   output logic [SPM_DIM_W-1:0]           out_row_idx,
   output logic                           out_row_last,
   output logic                           out_empty,
   output logic                           tag_done,
   output logic                           ovf_err,
   output logic                           cnt_err
);

   tag_state_t                      state, state_nxt;
   logic                            clr;
   logic                            init_q;
   logic [SPM_DIM_W-1:0]            nr_q;
   logic [SPM_DIM_W-1:0]            row_idx, row_nxt, row_inc;
   logic [DATA_W-1:0]               rem, rem_nxt;
   tag_tok_t                        tok_q, tok_nxt;
   logic                            out_vld_q;
   logic                            slot_free;
   logic                            issue;
   logic                            len_adv, nnz_adv;
   logic                            len_empty, nnz_empty;
   logic [DATA_W-1:0]               len_head;
   logic [2*DATA_W-1:0]             nnz_head;
   logic [NUM_CH-1:0][2*DATA_W-1:0] nnz_wr;

   assign clr = rst || spmv_init;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) nnz_wr[i] = {spm_val[i], spm_col_idx[i]};
   end

   spm_beat_fifo #(.NUM_CH(NUM_CH), .LANE_W(2*DATA_W)) u_nnz_fifo (
      .clk     (clk),
      .clr     (clr),
      .wr_val  (nnz_beat_val),
      .wr_data (nnz_wr),
      .wr_mask (last_not_valid),
      .adv     (nnz_adv),
      .rdy     (nnz_rdy),
      .empty   (nnz_empty),
      .head    (nnz_head)
   );

   spm_beat_fifo #(.NUM_CH(NUM_CH), .LANE_W(DATA_W)) u_len_fifo (
      .clk     (clk),
      .clr     (clr),
      .wr_val  (len_beat_val),
      .wr_data (spm_row_len),
      .wr_mask ('0),
      .adv     (len_adv),
      .rdy     (len_rdy),
      .empty   (len_empty),
      .head    (len_head)
   );

   // output register can take a new token when it is empty or being drained this cycle
   assign slot_free = !out_vld_q || out_rdy;
   assign row_inc   = row_idx + 1'b1;

   always_comb begin
      state_nxt = state;
      row_nxt   = row_idx;
      rem_nxt   = rem;
      tok_nxt   = '0;
      issue     = 1'b0;
      len_adv   = 1'b0;
      nnz_adv   = 1'b0;
      case (state)
         IDLE: begin
            if (init_q && !spmv_init) state_nxt = (nr_q == '0) ? DONE : LOAD;
         end
         LOAD: begin
            if (!len_empty) begin
               if (len_head == '0) begin
                  if (slot_free) begin
                     issue           = 1'b1;
                     tok_nxt.row_idx = row_idx;
                     tok_nxt.last    = 1'b1;
                     tok_nxt.empty   = 1'b1;
                     len_adv         = 1'b1;
                     row_nxt         = row_inc;
                     if (row_inc == nr_q) state_nxt = DONE;
                  end
               end else begin
                  rem_nxt   = len_head;
                  len_adv   = 1'b1;
                  state_nxt = STREAM;
               end
            end
         end
         STREAM: begin
            if (!nnz_empty && slot_free) begin
               issue           = 1'b1;
               tok_nxt.val     = nnz_head[2*DATA_W-1:DATA_W];
               tok_nxt.col_idx = nnz_head[DATA_W-1:0];
               tok_nxt.row_idx = row_idx;
               tok_nxt.last    = (rem == DATA_W'(1));
               nnz_adv         = 1'b1;
               rem_nxt         = rem - 1'b1;
               if (rem == DATA_W'(1)) begin
                  row_nxt   = row_inc;
                  state_nxt = (row_inc == nr_q) ? DONE : LOAD;
               end
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_q <= 1'b0;
         nr_q   <= '0;
      end else begin
         init_q <= spmv_init;
         if (spmv_init) nr_q <= spm_nr;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         row_idx   <= '0;
         rem       <= '0;
         tok_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         row_idx <= row_nxt;
         rem     <= rem_nxt;
         if (issue) begin
            tok_q     <= tok_nxt;
            out_vld_q <= 1'b1;
         end else if (out_rdy) begin
            out_vld_q <= 1'b0;
         end
      end
   end

   assign out_vld      = out_vld_q;
   assign out_val      = tok_q.val;
   assign out_col_idx  = tok_q.col_idx;
   assign out_row_idx  = tok_q.row_idx;
   assign out_row_last = tok_q.last;
   assign out_empty    = tok_q.empty;
   // the final token may still be waiting in the output register after entering DONE
   assign tag_done     = (state == DONE) && !out_vld_q;

`ifdef SPM_ROW_TAGGER_CHECK_EN
   logic [SPM_NNZ_W-1:0] nnz_q;
   logic [SPM_NNZ_W-1:0] elem_cnt, elem_cnt_nxt;
   logic                 ovf_q, cnt_err_q;

   assign elem_cnt_nxt = elem_cnt + SPM_NNZ_W'(issue && (state == STREAM));

   always_ff @(posedge clk) begin
      if (rst) nnz_q <= '0;
      else if (spmv_init) nnz_q <= spm_nnz;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         elem_cnt  <= '0;
         ovf_q     <= 1'b0;
         cnt_err_q <= 1'b0;
      end else begin
         elem_cnt <= elem_cnt_nxt;
         if ((nnz_beat_val && !nnz_rdy) || (len_beat_val && !len_rdy)) ovf_q <= 1'b1;
         if (state != DONE && state_nxt == DONE && elem_cnt_nxt != nnz_q) cnt_err_q <= 1'b1;
      end
   end

   assign ovf_err = ovf_q;
   assign cnt_err = cnt_err_q;
`else
   logic unused_nnz;
   assign unused_nnz = ^spm_nnz;
   assign ovf_err    = 1'b0;
   assign cnt_err    = 1'b0;
`endif

endmodule

// File: tb/tb_spm_row_tagger.sv
// Directed bench for spm_row_tagger with NUM_CH=4; tokens are collected at the
// output handshake and compared against hand-built expected lists.
module tb_spm_row_tagger;
   import spm_pkg::*;

   localparam int NC = 4;
   localparam int DW = 32;

   logic                    clk;
   logic                    rst;
   logic                    spmv_init;
   logic [SPM_DIM_W-1:0]    spm_nr;
   logic [SPM_NNZ_W-1:0]    spm_nnz;
   logic                    nnz_beat_val;
   logic [NC-1:0][DW-1:0]   spm_val;
   logic [NC-1:0][DW-1:0]   spm_col_idx;
   logic [NC-1:0]           last_not_valid;
   logic                    nnz_rdy;
   logic                    len_beat_val;
   logic [NC-1:0][DW-1:0]   spm_row_len;
   logic                    len_rdy;
   logic                    out_vld;
   logic                    out_rdy;
   logic [DW-1:0]           out_val;
   logic [DW-1:0]           out_col_idx;
   logic [SPM_DIM_W-1:0]    out_row_idx;
   logic                    out_row_last;
   logic                    out_empty;
   logic                    tag_done;
   logic                    ovf_err;
   logic                    cnt_err;

   int       total = 0;
   int       bad   = 0;
   logic     tog_en = 1'b0;
   logic     rdy_fix = 1'b1;
   tag_tok_t got_q[$];
   tag_tok_t exp_q[$];

`ifdef SPM_ROW_TAGGER_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   spm_row_tagger #(.NUM_CH(NC), .DATA_W(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .spmv_init      (spmv_init),
      .spm_nr         (spm_nr),
      .spm_nnz        (spm_nnz),
      .nnz_beat_val   (nnz_beat_val),
      .spm_val        (spm_val),
      .spm_col_idx    (spm_col_idx),
      .last_not_valid (last_not_valid),
      .nnz_rdy        (nnz_rdy),
      .len_beat_val   (len_beat_val),
      .spm_row_len    (spm_row_len),
      .len_rdy        (len_rdy),
      .out_vld        (out_vld),
      .out_rdy        (out_rdy),
      .out_val        (out_val),
      .out_col_idx    (out_col_idx),
      .out_row_idx    (out_row_idx),
      .out_row_last   (out_row_last),
      .out_empty      (out_empty),
      .tag_done       (tag_done),
      .ovf_err        (ovf_err),
      .cnt_err        (cnt_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic tag_tok_t tk(input logic [31:0] v, input logic [31:0] c,
                                   input int row, input logic last, input logic empty);
      tag_tok_t t;
      t.val     = v;
      t.col_idx = c;
      t.row_idx = SPM_DIM_W'(row);
      t.last    = last;
      t.empty   = empty;
      return t;
   endfunction

   function automatic tag_tok_t cur_tok();
      tag_tok_t t;
      t.val     = out_val;
      t.col_idx = out_col_idx;
      t.row_idx = out_row_idx;
      t.last    = out_row_last;
      t.empty   = out_empty;
      return t;
   endfunction

   // ready driver: fixed level or toggling every cycle
   initial begin
      out_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) out_rdy = ~out_rdy;
         else out_rdy = rdy_fix;
      end
   end

   // token collector and hold-while-stalled check
   initial begin
      tag_tok_t held;
      tag_tok_t cur;
      logic     prev_stall;
      prev_stall = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         cur = cur_tok();
         if (prev_stall && !rst && !spmv_init) chk("hold", 128'(cur), 128'(held));
         if (out_vld && out_rdy) got_q.push_back(cur);
         prev_stall = out_vld && !out_rdy;
         held = cur;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int nr, input int nnz);
      spm_nr    = SPM_DIM_W'(nr);
      spm_nnz   = SPM_NNZ_W'(nnz);
      spmv_init = 1'b1;
      tick();
      spmv_init = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic push_nnz(input logic [NC-1:0][DW-1:0] v, input logic [NC-1:0][DW-1:0] c,
                           input logic [NC-1:0] m);
      spm_val        = v;
      spm_col_idx    = c;
      last_not_valid = m;
      nnz_beat_val   = 1'b1;
      tick();
      nnz_beat_val   = 1'b0;
   endtask

   task automatic push_len(input logic [NC-1:0][DW-1:0] l);
      spm_row_len  = l;
      len_beat_val = 1'b1;
      tick();
      len_beat_val = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!tag_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 128'(tag_done), 128'(1));
   endtask

   task automatic check_stream(input string tag);
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      chk({tag, "_ntok"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < n; i++) chk($sformatf("%s_tok%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic measure_lat(input string tag, input int want);
      int lat;
      lat = 0;
      @(negedge clk);
      while (!out_vld && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk(tag, 128'(lat), 128'(want));
   endtask

   task automatic run_basic(input string tag);
      logic [NC-1:0][DW-1:0] v, c, l;
      v = {32'hD0, 32'hC0, 32'hB0, 32'hA0};
      c = {32'd13, 32'd12, 32'd11, 32'd10};
      l = {32'd0, 32'd0, 32'd2, 32'd2};
      start(2, 4);
      push_nnz(v, c, 4'b0000);
      push_len(l);
      measure_lat({tag, "_lat"}, 2);
      wait_done({tag, "_done"});
      exp_q.push_back(tk(32'hA0, 32'd10, 0, 1'b0, 1'b0));
      exp_q.push_back(tk(32'hB0, 32'd11, 0, 1'b1, 1'b0));
      exp_q.push_back(tk(32'hC0, 32'd12, 1, 1'b0, 1'b0));
      exp_q.push_back(tk(32'hD0, 32'd13, 1, 1'b1, 1'b0));
      check_stream(tag);
      chk({tag, "_cnt_err"}, 128'(cnt_err), 128'(0));
   endtask

   initial begin
      logic [NC-1:0][DW-1:0] v, c, l;
      int n;
      rst = 1'b1;
      spmv_init = 1'b0;
      spm_nr = '0;
      spm_nnz = '0;
      nnz_beat_val = 1'b0;
      len_beat_val = 1'b0;
      spm_val = '0;
      spm_col_idx = '0;
      spm_row_len = '0;
      last_not_valid = '0;
      tick();
      tick();
      chk("rst_vld", 128'(out_vld), 128'(0));
      chk("rst_val", 128'(out_val), 128'(0));
      chk("rst_nnz_rdy", 128'(nnz_rdy), 128'(1));
      chk("rst_len_rdy", 128'(len_rdy), 128'(1));
      chk("rst_done", 128'(tag_done), 128'(0));
      chk("rst_ovf", 128'(ovf_err), 128'(0));
      chk("rst_cnt", 128'(cnt_err), 128'(0));
      rst = 1'b0;
      tick();

      // two rows of two
      run_basic("t1");
      chk("t1_ovf", 128'(ovf_err), 128'(0));

      // empty rows interleaved
      v = {32'h44, 32'h33, 32'h22, 32'h11};
      c = {32'd4, 32'd3, 32'd2, 32'd1};
      l = {32'd1, 32'd0, 32'd3, 32'd0};
      start(4, 4);
      push_nnz(v, c, 4'b0000);
      push_len(l);
      measure_lat("t2_lat", 1);
      wait_done("t2_done");
      exp_q.push_back(tk(32'h0, 32'd0, 0, 1'b1, 1'b1));
      exp_q.push_back(tk(32'h11, 32'd1, 1, 1'b0, 1'b0));
      exp_q.push_back(tk(32'h22, 32'd2, 1, 1'b0, 1'b0));
      exp_q.push_back(tk(32'h33, 32'd3, 1, 1'b1, 1'b0));
      exp_q.push_back(tk(32'h0, 32'd0, 2, 1'b1, 1'b1));
      exp_q.push_back(tk(32'h44, 32'd4, 3, 1'b1, 1'b0));
      check_stream("t2");

      // row of 6 across two beats with out_rdy toggling
      start(1, 6);
      tog_en = 1'b1;
      push_nnz({32'h503, 32'h502, 32'h501, 32'h500}, {32'd53, 32'd52, 32'd51, 32'd50}, 4'b0000);
      push_nnz({32'h507, 32'h506, 32'h505, 32'h504}, {32'd57, 32'd56, 32'd55, 32'd54}, 4'b0000);
      push_len({32'd0, 32'd0, 32'd0, 32'd6});
      wait_done("t3_done");
      tog_en = 1'b0;
      for (int i = 0; i < 6; i++)
         exp_q.push_back(tk(32'h500 + 32'(i), 32'd50 + 32'(i), 0, (i == 5), 1'b0));
      check_stream("t3");
      chk("t3_ovf", 128'(ovf_err), 128'(0));

      // tail lanes masked off in second beat
      start(2, 5);
      push_nnz({32'hD4, 32'hC4, 32'hB4, 32'hA4}, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0000);
      push_nnz({32'hFF3, 32'hFF2, 32'hFF1, 32'hE4}, {32'd99, 32'd98, 32'd97, 32'd5}, 4'b1110);
      push_len({32'd0, 32'd0, 32'd2, 32'd3});
      wait_done("t4_done");
      exp_q.push_back(tk(32'hA4, 32'd1, 0, 1'b0, 1'b0));
      exp_q.push_back(tk(32'hB4, 32'd2, 0, 1'b0, 1'b0));
      exp_q.push_back(tk(32'hC4, 32'd3, 0, 1'b1, 1'b0));
      exp_q.push_back(tk(32'hD4, 32'd4, 1, 1'b0, 1'b0));
      exp_q.push_back(tk(32'hE4, 32'd5, 1, 1'b1, 1'b0));
      check_stream("t4");
      chk("t4_cnt_err", 128'(cnt_err), 128'(0));

      // element count mismatch: 2 emitted, 3 declared
      start(1, 3);
      push_nnz({32'h0, 32'h0, 32'h72, 32'h71}, {32'd0, 32'd0, 32'd2, 32'd1}, 4'b1100);
      push_len({32'd0, 32'd0, 32'd0, 32'd2});
      wait_done("t4b_done");
      exp_q.push_back(tk(32'h71, 32'd1, 0, 1'b0, 1'b0));
      exp_q.push_back(tk(32'h72, 32'd2, 0, 1'b1, 1'b0));
      check_stream("t4b");
      chk("t4b_cnt_err", 128'(cnt_err), 128'(CHK));

      // overflow: three beats with nothing popping
      rst = 1'b1;
      tick();
      rst = 1'b0;
      spm_val = '0;
      spm_col_idx = '0;
      last_not_valid = '0;
      nnz_beat_val = 1'b1;
      tick();
      chk("t5_rdy1", 128'(nnz_rdy), 128'(1));
      tick();
      chk("t5_rdy2", 128'(nnz_rdy), 128'(0));
      chk("t5_len_rdy", 128'(len_rdy), 128'(1));
      chk("t5_ovf_pre", 128'(ovf_err), 128'(0));
      tick();
      nnz_beat_val = 1'b0;
      chk("t5_ovf", 128'(ovf_err), 128'(CHK));
      chk("t5_rdy3", 128'(nnz_rdy), 128'(0));

      // reset mid-row, then a clean re-run
      start(1, 6);
      push_nnz({32'h603, 32'h602, 32'h601, 32'h600}, {32'd3, 32'd2, 32'd1, 32'd0}, 4'b0000);
      push_nnz({32'h607, 32'h606, 32'h605, 32'h604}, {32'd7, 32'd6, 32'd5, 32'd4}, 4'b0000);
      push_len({32'd0, 32'd0, 32'd0, 32'd6});
      n = 0;
      while (got_q.size() < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_mid", 128'(got_q.size() >= 2), 128'(1));
      rst = 1'b1;
      tick();
      chk("t6_vld", 128'(out_vld), 128'(0));
      chk("t6_row", 128'(out_row_idx), 128'(0));
      chk("t6_nnz_rdy", 128'(nnz_rdy), 128'(1));
      chk("t6_len_rdy", 128'(len_rdy), 128'(1));
      chk("t6_ovf", 128'(ovf_err), 128'(0));
      rst = 1'b0;
      tick();
      chk("t6_idle", 128'(tag_done), 128'(0));
      run_basic("t6r");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
